// File: rtl/spi_frontend_pkg.sv
// Shared types and constants for the SPI register front end.
package spi_frontend_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam int CMD_BITS   = 8;
    localparam int ADDR_W     = 7;

    // Full 7-bit compare: any set high bit pushes the address past NREG.
    function automatic logic addr_hit(input logic [ADDR_W-1:0] addr, input int nreg);
        return (int'(addr) < nreg);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous input, followed by a
// one-flop rise/fall detector on the synchronised level.
module spi_sync #(
    parameter int   SYNC_FF = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_FF-1:0] sync_r;
    logic               prev_r;

    // Synchroniser chain plus previous-level flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_FF{RST_VAL}};
            prev_r <= RST_VAL;
        end else begin
            sync_r <= {sync_r[SYNC_FF-2:0], d};
            prev_r <= sync_r[SYNC_FF-1];
        end
    end

    assign q    = sync_r[SYNC_FF-1];
    assign rise = sync_r[SYNC_FF-1] & ~prev_r;
    assign fall = ~sync_r[SYNC_FF-1] & prev_r;

endmodule

// File: rtl/spi_reg_frontend.sv
// SPI mode-0 slave writing 16-bit frames into an NREG x 8-bit register file.
// Optional MISO read-back is built when SPI_READBACK_EN is defined.
module spi_reg_frontend
    import spi_frontend_pkg::*;
#(
    parameter int NREG    = 4,
    parameter int SYNC_FF = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              sclk_i,
    input  logic              cs_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe,
    output logic [NREG*8-1:0] reg_out,
    output logic              wr_strobe,
    output logic [2:0]        wr_addr
);

    localparam int         AW        = $clog2(NREG);
    localparam logic [4:0] CNT_CMD   = 5'(CMD_BITS);
    localparam logic [4:0] CNT_FRAME = 5'(FRAME_BITS);

    logic sclk_q_s, sclk_rise_s, sclk_fall_s;
    logic cs_q_s, cs_rise_s, cs_fall_s;
    logic mosi_q_s, mosi_rise_s, mosi_fall_s;
    logic cs_high_s, take_bit_s, commit_s;
    logic unused_sync_s;

    state_t                 state_r, state_nxt_s;
    logic [4:0]             bit_cnt_r, cnt_inc_s;
    logic [FRAME_BITS-1:0]  shift_r, frame_nxt_s;
    logic [7:0]             regs_r [NREG];
    logic                   wr_strobe_r;
    logic [2:0]             wr_addr_r;

    spi_sync #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk_i),
        .q(sclk_q_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );
    spi_sync #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d(cs_n_i),
        .q(cs_q_s), .rise(cs_rise_s), .fall(cs_fall_s)
    );
    spi_sync #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(mosi_i),
        .q(mosi_q_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
    );

    // A deselected or disabled tile behaves exactly like cs_n high.
    assign cs_high_s   = cs_q_s | ~ena;
    assign take_bit_s  = sclk_rise_s & ~cs_high_s & ((state_r == CMD) | (state_r == DATA));
    assign cnt_inc_s   = bit_cnt_r + 5'd1;
    assign frame_nxt_s = {shift_r[FRAME_BITS-2:0], mosi_q_s};
    assign commit_s    = take_bit_s & (state_r == DATA) & (cnt_inc_s == CNT_FRAME)
                       & frame_nxt_s[15] & addr_hit(frame_nxt_s[14:8], NREG);
    assign unused_sync_s = ^{sclk_q_s, sclk_fall_s, cs_rise_s, mosi_rise_s, mosi_fall_s, shift_r[15]};

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; deselect wins over every other event.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (cs_fall_s && !cs_high_s) state_nxt_s = CMD;
                else                         state_nxt_s = IDLE;
            end
            CMD: begin
                if (cs_high_s)                                  state_nxt_s = IDLE;
                else if (take_bit_s && (cnt_inc_s == CNT_CMD))  state_nxt_s = DATA;
                else                                            state_nxt_s = CMD;
            end
            DATA: begin
                if (cs_high_s)                                    state_nxt_s = IDLE;
                else if (take_bit_s && (cnt_inc_s == CNT_FRAME))  state_nxt_s = DONE;
                else                                              state_nxt_s = DATA;
            end
            DONE: begin
                if (cs_high_s) state_nxt_s = IDLE;
                else           state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Bit counter (saturating) and MOSI shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r <= 5'd0;
            shift_r   <= 16'h0000;
        end else if ((state_r == IDLE) || cs_high_s) begin
            bit_cnt_r <= 5'd0;
            shift_r   <= 16'h0000;
        end else if (take_bit_s) begin
            bit_cnt_r <= (bit_cnt_r == CNT_FRAME) ? bit_cnt_r : cnt_inc_s;
            shift_r   <= frame_nxt_s;
        end else begin
            bit_cnt_r <= bit_cnt_r;
            shift_r   <= shift_r;
        end
    end

    // Register file and write strobe, updated the cycle after the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREG; k++) regs_r[k] <= 8'h00;
            wr_strobe_r <= 1'b0;
            wr_addr_r   <= 3'd0;
        end else begin
            wr_strobe_r <= commit_s;
            if (commit_s) begin
                regs_r[frame_nxt_s[8 +: AW]] <= frame_nxt_s[7:0];
                wr_addr_r                    <= frame_nxt_s[10:8];
            end
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign reg_out[8*g +: 8] = regs_r[g];
    end

    assign wr_strobe = wr_strobe_r;
    assign wr_addr   = wr_addr_r;

`ifdef SPI_READBACK_EN
    logic [7:0] rd_shift_r, rd_byte_s;
    logic       miso_oe_r, rd_load_s, rd_adv_s;

    assign rd_load_s = take_bit_s & (state_r == CMD) & (cnt_inc_s == CNT_CMD);
    // First fall after the command byte keeps DATA[7] on the pin for the 9th rise.
    assign rd_adv_s  = sclk_fall_s & ((state_r == DATA) | (state_r == DONE)) & (bit_cnt_r > CNT_CMD);

    // Read mux: write frames and misses return zero.
    always_comb begin
        rd_byte_s = 8'h00;
        if (!frame_nxt_s[7] && addr_hit(frame_nxt_s[6:0], NREG)) begin
            rd_byte_s = regs_r[frame_nxt_s[0 +: AW]];
        end else begin
            rd_byte_s = 8'h00;
        end
    end

    // MISO shift register and output enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_shift_r <= 8'h00;
            miso_oe_r  <= 1'b0;
        end else begin
            miso_oe_r <= (state_nxt_s == DATA) || (state_nxt_s == DONE);
            if (state_nxt_s == IDLE)  rd_shift_r <= 8'h00;
            else if (rd_load_s)       rd_shift_r <= rd_byte_s;
            else if (rd_adv_s)        rd_shift_r <= {rd_shift_r[6:0], 1'b0};
            else                      rd_shift_r <= rd_shift_r;
        end
    end

    assign miso_o  = rd_shift_r[7];
    assign miso_oe = miso_oe_r;
`else
    assign miso_o  = 1'b0;
    assign miso_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_frontend.sv
// Self-checking bench for spi_reg_frontend: directed scenarios then random frames
// against an array model of the register file.
module tb_spi_reg_frontend;

    logic        clk = 1'b0;
    logic        rst_n, ena, sclk, cs_n, mosi;
    logic        miso_o, miso_oe, wr_strobe;
    logic [31:0] reg_out;
    logic [2:0]  wr_addr;

    int          n_checks = 0;
    int          n_err    = 0;
    int          strobe_cnt = 0;
    logic [2:0]  last_addr = 3'd0;
    logic        miso_seen = 1'b0;
    logic [7:0]  model [4];

    spi_reg_frontend #(.NREG(4), .SYNC_FF(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sclk_i(sclk), .cs_n_i(cs_n),
        .mosi_i(mosi), .miso_o(miso_o), .miso_oe(miso_oe), .reg_out(reg_out),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            strobe_cnt = strobe_cnt + 1;
            last_addr  = wr_addr;
        end
    end

    function automatic logic [31:0] model_flat();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ev_kind: 0 none, 1 drop ena at bit ev_at, 2 pulse rst_n at bit ev_at
    task automatic spi_xfer(input logic [31:0] pat, input int nbits, input int half,
                            input int ev_at, input int ev_kind,
                            output logic [7:0] rd, output logic oe_cmd, output logic oe_data);
        rd = 8'h00; oe_cmd = 1'b0; oe_data = 1'b0;
        cs_n = 1'b0;
        #(3*half);
        for (int i = 0; i < nbits; i++) begin
            if (i == ev_at && ev_kind == 1) ena = 1'b0;
            if (i == ev_at && ev_kind == 2) begin
                rst_n = 1'b0;
                #1;
                check("rst_mid_reg_out", reg_out, 32'h0);
                check("rst_mid_strobe", {31'd0, wr_strobe}, 32'd0);
                check("rst_mid_miso_oe", {31'd0, miso_oe}, 32'd0);
                #(half-1);
                rst_n = 1'b1;
            end
            mosi = pat[31-i];
            #half;
            if (i >= 8 && i < 16) rd = {rd[6:0], miso_o};
            if (i == 4)  oe_cmd  = miso_oe;
            if (i == 12) oe_data = miso_oe;
            miso_seen = miso_seen | miso_o | miso_oe;
            sclk = 1'b1;
            #half;
            sclk = 1'b0;
        end
        #half;
        cs_n = 1'b1;
        #(4*half);
        ena = 1'b1;
    endtask

    initial begin
        logic [7:0]  rd;
        logic        oe_c, oe_d;
        int          s0, exp_strobes, nbits, half;
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  data;

        rst_n = 1'b0; ena = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        for (int k = 0; k < 4; k++) model[k] = 8'h00;
        #23;
        check("reset_reg_out", reg_out, 32'h0);
        check("reset_strobe", {31'd0, wr_strobe}, 32'd0);
        check("reset_wr_addr", {29'd0, wr_addr}, 32'd0);
        check("reset_miso", {31'd0, miso_o}, 32'd0);
        check("reset_miso_oe", {31'd0, miso_oe}, 32'd0);
        rst_n = 1'b1;
        #40;

        // Basic write to reg 2
        s0 = strobe_cnt;
        spi_xfer({16'h82A5, 16'h0}, 16, 20, -1, 0, rd, oe_c, oe_d);
        model[2] = 8'hA5;
        check("write_a5_regs", reg_out, model_flat());
        check("write_a5_strobes", strobe_cnt - s0, 32'd1);
        check("write_a5_addr", {29'd0, last_addr}, 32'd2);

        // Reset in the middle of a frame, then a full frame
        spi_xfer({16'h8144, 16'h0}, 16, 20, 6, 2, rd, oe_c, oe_d);
        for (int k = 0; k < 4; k++) model[k] = 8'h00;
        check("after_rst_frame_regs", reg_out, model_flat());
        s0 = strobe_cnt;
        spi_xfer({16'h8311, 16'h0}, 16, 20, -1, 0, rd, oe_c, oe_d);
        model[3] = 8'h11;
        check("post_rst_write_regs", reg_out, model_flat());
        check("post_rst_write_strobes", strobe_cnt - s0, 32'd1);

        // Aborted frame, then an over-long frame
        s0 = strobe_cnt;
        spi_xfer({16'h81FF, 16'h0}, 12, 20, -1, 0, rd, oe_c, oe_d);
        check("abort_strobes", strobe_cnt - s0, 32'd0);
        check("abort_regs", reg_out, model_flat());
        s0 = strobe_cnt;
        spi_xfer({16'h8133, 16'hF000}, 20, 20, -1, 0, rd, oe_c, oe_d);
        model[1] = 8'h33;
        check("long_frame_regs", reg_out, model_flat());
        check("long_frame_strobes", strobe_cnt - s0, 32'd1);
        check("long_frame_addr", {29'd0, last_addr}, 32'd1);

        // Address miss and ena drop
        s0 = strobe_cnt;
        spi_xfer({16'h8977, 16'h0}, 16, 20, -1, 0, rd, oe_c, oe_d);
        check("miss_strobes", strobe_cnt - s0, 32'd0);
        check("miss_regs", reg_out, model_flat());
        s0 = strobe_cnt;
        spi_xfer({16'h8255, 16'h0}, 16, 20, 10, 1, rd, oe_c, oe_d);
        check("ena_drop_strobes", strobe_cnt - s0, 32'd0);
        check("ena_drop_regs", reg_out, model_flat());

        // Read-back
        spi_xfer({16'h833C, 16'h0}, 16, 20, -1, 0, rd, oe_c, oe_d);
        model[3] = 8'h3C;
        check("rb_write_regs", reg_out, model_flat());
        s0 = strobe_cnt;
        spi_xfer({16'h0300, 16'h0}, 16, 50, -1, 0, rd, oe_c, oe_d);
        check("read_strobes", strobe_cnt - s0, 32'd0);
        check("read_regs", reg_out, model_flat());
`ifdef SPI_READBACK_EN
        check("read_addr3_data", {24'd0, rd}, 32'h3C);
        check("read_oe_cmd", {31'd0, oe_c}, 32'd0);
        check("read_oe_data", {31'd0, oe_d}, 32'd1);
`else
        check("read_addr3_data", {24'd0, rd}, 32'h00);
        check("read_oe_cmd", {31'd0, oe_c}, 32'd0);
        check("read_oe_data", {31'd0, oe_d}, 32'd0);
`endif
        spi_xfer({16'h0500, 16'h0}, 16, 50, -1, 0, rd, oe_c, oe_d);
        check("read_miss_data", {24'd0, rd}, 32'h00);
        check("idle_miso_oe", {31'd0, miso_oe}, 32'd0);

        // Random frames against the model
        miso_seen   = 1'b0;
        exp_strobes = 0;
        s0 = strobe_cnt;
        for (int f = 0; f < 200; f++) begin
            rw   = ($urandom % 4) != 0;
            addr = (($urandom % 8) == 0) ? (7'h40 | 7'($urandom_range(0, 63)))
                                         : 7'($urandom_range(0, 5));
            data = 8'($urandom);
            case ($urandom % 10)
                0:       nbits = 11;
                1:       nbits = 20;
                default: nbits = 16;
            endcase
            half = 20 + 5 * $urandom_range(0, 2);
            #($urandom_range(0, 9));
            spi_xfer({rw, addr, data, 16'($urandom)}, nbits, half, -1, 0, rd, oe_c, oe_d);
            if (nbits >= 16 && rw && addr < 7'd4) begin
                model[addr[1:0]] = data;
                exp_strobes++;
            end
            check("random_regs", reg_out, model_flat());
        end
        check("random_strobes", strobe_cnt - s0, exp_strobes);
`ifndef SPI_READBACK_EN
        check("random_miso_quiet", {31'd0, miso_seen}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
